// File: rtl/run_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// run_seq_gen_pkg
// Shared types and defaults for the run-length serial bit generator.
//   eng_state_t  : engine state (IDLE, EMIT)
//   run_cmd_t    : {level, len} command layout at the default length width;
//                  the FIFO word in run_seq_gen uses the same field order
//                  ({level, len}) at whatever LEN_W the top is built with.
//   *_DEF        : default parameter values for the top.
// -----------------------------------------------------------------------------
package run_seq_gen_pkg;

   localparam int LEN_W_DEF      = 4;
   localparam int DEPTH_DEF      = 4;
   localparam int RUN_THRESH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } eng_state_t;

   typedef struct packed {
      logic                 level;
      logic [LEN_W_DEF-1:0] len;
   } run_cmd_t;

   // Width of a saturating counter that must be able to hold thresh.
   function automatic int sat_cnt_width(input int thresh);
      return $clog2(thresh) + 1;
   endfunction

endpackage

// File: rtl/run_cmd_fifo.sv
// -----------------------------------------------------------------------------
// run_cmd_fifo
// Small synchronous FIFO holding run commands. Show-ahead: rd_data always
// presents the head entry, so the engine can load it on the same edge it pops.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   wr_en, wr_data   write request (ignored when full)
//   rd_en, rd_data   pop request (ignored when empty), head entry
//   full, empty      occupancy flags (registered state only)
//   count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module run_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem[rd_ptr_reg];

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/run_seq_gen.sv
// -----------------------------------------------------------------------------
// run_seq_gen
// Run-length serial bit generator. Accepts {level, length} commands over a
// valid/ready handshake, buffers them, and emits one bit per clock on sout.
// expect_out predicts, one-for-one, the output of a Moore run detector that
// samples sout on the same clock and asserts after RUN_THRESH equal bits.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   cmd_valid    command offered            cmd_ready   FIFO not full
//   cmd_level    run bit value              cmd_len     run length (0 = drop)
//   sout         registered serial bit      busy        run active or queued
//   fifo_count   buffered commands          expect_out  predicted detector out
// -----------------------------------------------------------------------------
module run_seq_gen
   import run_seq_gen_pkg::*;
#(
   parameter int LEN_W      = LEN_W_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int RUN_THRESH = RUN_THRESH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_level,
   input  logic [LEN_W-1:0]       cmd_len,
   output logic                   sout,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   expect_out
);

   localparam int CNT_W = sat_cnt_width(RUN_THRESH);
   localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

   // FIFO word layout matches run_cmd_t: {level, len}
   logic [LEN_W:0]   head;
   logic             head_level;
   logic [LEN_W-1:0] head_len;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   eng_state_t       state_reg, state_next;
   logic [LEN_W-1:0] remaining_reg, remaining_next;
   logic             sout_reg, sout_next;

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             last_reg;
   logic             first_reg;
   logic             expect_reg;

   // Ready depends only on stored occupancy, never on cmd_valid or a pop.
   assign cmd_ready = ~full;
   // Zero-length commands complete the handshake but are never stored.
   assign push      = cmd_valid & cmd_ready & (cmd_len != '0);

   assign head_level = head[LEN_W];
   assign head_len   = head[LEN_W-1:0];

   run_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LEN_W + 1)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data ({cmd_level, cmd_len}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   // Engine: remaining counts bits still to show after the current one, so
   // remaining==0 in EMIT marks the last bit and lets the next run load on
   // that same edge without an idle bubble.
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      sout_next      = sout_reg;
      pop            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop            = 1'b1;
               sout_next      = head_level;
               remaining_next = head_len - LEN_W'(1);
               state_next     = EMIT;
            end
         end
         EMIT: begin
            if (remaining_reg != '0) begin
               remaining_next = remaining_reg - LEN_W'(1);
            end else if (!empty) begin
               pop            = 1'b1;
               sout_next      = head_level;
               remaining_next = head_len - LEN_W'(1);
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Detector model: the current sout is the sample taken at this edge.
   always_comb begin
      cnt_next = CNT_W'(1);
      if (!first_reg && (sout_reg == last_reg)) begin
         cnt_next = (cnt_reg == THRESH) ? THRESH : cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         sout_reg      <= 1'b0;
         cnt_reg       <= '0;
         last_reg      <= 1'b0;
         first_reg     <= 1'b1;
         expect_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         sout_reg      <= sout_next;
         cnt_reg       <= cnt_next;
         last_reg      <= sout_reg;
         first_reg     <= 1'b0;
         expect_reg    <= (cnt_next == THRESH);
      end
   end

   assign sout       = sout_reg;
   assign expect_out = expect_reg;
   assign busy       = (state_reg == EMIT) | (fifo_count != '0);

endmodule

// File: tb/tb_run_seq_gen.sv
module tb_run_seq_gen;

   localparam int LEN_W      = 4;
   localparam int DEPTH      = 4;
   localparam int RUN_THRESH = 4;
   localparam int CW         = $clog2(DEPTH) + 1;
   localparam int LOGN       = 16384;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_level = 1'b0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             sout;
   logic             busy;
   logic [CW-1:0]    fifo_count;
   logic             expect_out;

   run_seq_gen #(
      .LEN_W      (LEN_W),
      .DEPTH      (DEPTH),
      .RUN_THRESH (RUN_THRESH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_level  (cmd_level),
      .cmd_len    (cmd_len),
      .sout       (sout),
      .busy       (busy),
      .fifo_count (fifo_count),
      .expect_out (expect_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bit sout_log  [LOGN];
   bit exp_log   [LOGN];
   bit busy_log  [LOGN];
   int count_log [LOGN];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Queue of accepted commands, number of bits of the current run still to
   // be shown (including the one on the line), and the recent sout samples.
   typedef struct {
      bit level;
      int len;
   } mcmd_t;

   mcmd_t m_q[$];
   mcmd_t m_c;
   int    m_left = 0;
   bit    m_sout = 1'b0;
   bit    m_hist[$];
   bit    m_exp = 1'b0;
   bit    m_acc;

   always @(posedge clk) begin
      if (!reset) begin
         m_q.delete();
         m_hist.delete();
         m_left = 0;
         m_sout = 1'b0;
         m_exp  = 1'b0;
      end else begin
         // detector: high once the last RUN_THRESH samples are all equal
         m_hist.push_back(m_sout);
         if (m_hist.size() > RUN_THRESH) m_hist.delete(0);
         m_exp = (m_hist.size() == RUN_THRESH);
         foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_exp = 1'b0;
         // handshake uses the occupancy before this edge
         m_acc = cmd_valid && (m_q.size() < DEPTH) && (cmd_len != '0);
         // a new run starts when the line is idle or on its last bit
         if (m_left <= 1 && m_q.size() > 0) begin
            m_c    = m_q.pop_front();
            m_sout = m_c.level;
            m_left = m_c.len;
         end else if (m_left > 0) begin
            m_left--;
         end
         if (m_acc) begin
            m_c.level = cmd_level;
            m_c.len   = int'(cmd_len);
            m_q.push_back(m_c);
         end
      end
      cyc++;
      #1;
      check("cyc_sout",   int'(sout),       int'(m_sout));
      check("cyc_expect", int'(expect_out), int'(m_exp));
      check("cyc_busy",   int'(busy),       int'(m_left > 0 || m_q.size() > 0));
      check("cyc_count",  int'(fifo_count), m_q.size());
      check("cyc_ready",  int'(cmd_ready),  int'(m_q.size() < DEPTH));
      if (cyc < LOGN) begin
         sout_log[cyc]  = sout;
         exp_log[cyc]   = expect_out;
         busy_log[cyc]  = busy;
         count_log[cyc] = int'(fifo_count);
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(output int rel);
      cmd_valid = 1'b0;
      reset     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rel   = cyc;
   endtask

   // Holds the command until the edge that accepts it; returns that edge.
   task automatic send(input bit lvl, input int len, output int acc);
      int  waits;
      bit  rdy;
      waits     = 0;
      acc       = -1;
      cmd_valid = 1'b1;
      cmd_level = lvl;
      cmd_len   = LEN_W'(len);
      while (waits < 200) begin
         rdy = cmd_ready;
         @(negedge clk);
         if (rdy) begin
            acc = cyc;
            break;
         end
         waits++;
      end
      if (acc < 0) check("send_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, t, a, n, len_r;
      int pat2[10];
      int pat4[5];
      pat2 = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      pat4 = '{1, 1, 1, 1, 0};

      @(negedge clk);

      // 1: idle line after reset, zeros count as a run
      do_reset(r);
      idle(6);
      for (int k = 1; k <= 6; k++) begin
         check("t1_sout", int'(sout_log[r+k]), 0);
         check("t1_expect", int'(exp_log[r+k]), (k >= 4) ? 1 : 0);
      end

      // 2: {1,3} then {0,5}
      do_reset(r);
      send(1'b1, 3, t);
      send(1'b0, 5, a);
      check("t2_first_accept", t, r + 1);
      check("t2_second_accept", a, r + 2);
      idle(12);
      for (int k = 1; k <= 10; k++) check("t2_sout", int'(sout_log[t+k]), pat2[k-1]);
      for (int k = 1; k <= 9; k++) check("t2_expect", int'(exp_log[t+k]), (k >= 8) ? 1 : 0);

      // 3: fill the FIFO behind a long run, then a held offer
      do_reset(r);
      send(1'b1, 15, t);
      for (int i = 0; i < DEPTH; i++) begin
         send(1'b1, 2, a);
         check("t3_fill_accept", a, t + 1 + i);
      end
      check("t3_ready_full", int'(cmd_ready), 0);
      check("t3_count_full", int'(fifo_count), DEPTH);
      send(1'b1, 2, a);
      check("t3_held_accept", a, t + 17);
      idle(12);
      n = 0;
      for (int k = 1; k <= 15 + 2 * (DEPTH + 1); k++) n += int'(sout_log[t+k]);
      check("t3_ones", n, 15 + 2 * (DEPTH + 1));
      check("t3_busy_last", int'(busy_log[t + 15 + 2 * (DEPTH + 1)]), 1);
      check("t3_busy_done", int'(busy_log[t + 16 + 2 * (DEPTH + 1)]), 0);

      // 4: zero-length command is handshaken and dropped
      do_reset(r);
      send(1'b1, 4, t);
      send(1'b1, 0, a);
      check("t4_zero_accept", a, t + 1);
      send(1'b0, 1, a);
      check("t4_first_accept", t, r + 1);
      idle(10);
      for (int k = 1; k <= 5; k++) check("t4_sout", int'(sout_log[t+k]), pat4[k-1]);
      for (int k = 1; k <= 8; k++) check("t4_expect", int'(exp_log[t+k]), (k == 5) ? 1 : 0);
      check("t4_count_drop", count_log[t+1], 0);
      check("t4_count_write", count_log[t+2], 1);

      // 5: asynchronous reset in the middle of a run
      do_reset(r);
      send(1'b1, 10, t);
      send(1'b0, 3, a);
      send(1'b1, 2, a);
      idle(3);
      check("t5_pre_sout", int'(sout), 1);
      check("t5_pre_count", int'(fifo_count), 2);
      reset = 1'b0;
      #1;
      check("t5_rst_sout", int'(sout), 0);
      check("t5_rst_count", int'(fifo_count), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_ready", int'(cmd_ready), 1);
      @(negedge clk);
      reset = 1'b1;
      r = cyc;
      send(1'b1, 3, t);
      check("t5_accept", t, r + 1);
      idle(6);
      check("t5_sout_pop_edge", int'(sout_log[t]), 0);
      for (int k = 1; k <= 3; k++) check("t5_sout_run", int'(sout_log[t+k]), 1);

      // 6: alternating single-bit runs
      do_reset(r);
      t = r + 1;
      for (int i = 0; i < 16; i++) begin
         send(bit'(i % 2), 1, a);
         check("t6_accept", a, t + i);
      end
      idle(4);
      for (int i = 0; i < 16; i++) check("t6_sout", int'(sout_log[t+1+i]), i % 2);
      for (int k = 0; k <= 16; k++) check("t6_expect", int'(exp_log[t+k]), 0);

      // 7: randomized traffic against the model
      do_reset(r);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) len_r = 0;
         else if ($urandom_range(0, 3) == 0) len_r = int'($urandom_range(1, 15));
         else len_r = int'($urandom_range(1, 3));
         send(bit'($urandom_range(0, 1)), len_r, a);
         if ($urandom_range(0, 99) == 0) do_reset(r);
         else if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
